// File: rtl/prog_loader_if.sv
// Program-RAM write port driven by prog_loader.
interface prog_loader_if;
  logic [10:0] ram_addr;
  logic [7:0]  ram_data;
  logic        ram_we;

  modport master (output ram_addr, ram_data, ram_we);
  modport slave  (input  ram_addr, ram_data, ram_we);
endinterface

// File: rtl/prog_loader.sv
// UART 8N1 program loader: A5 | len | data... [| sum] into program RAM.
// Define PROG_LOADER_CHECKSUM_EN to enable the trailing checksum byte.
module prog_loader #(
  parameter int          CLKS_PER_BIT = 434,
  parameter logic [10:0] START_ADDR   = 11'h000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rx,
  prog_loader_if.master ram,
  output logic          cpu_hold,
  output logic          load_done,
  output logic          load_err
);
  localparam logic [15:0] BIT_END  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_END = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [7:0]  SYNC     = 8'hA5;

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} ust_t;

`ifdef PROG_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    WAIT_SYNC, GET_LEN, GET_DATA, GET_SUM, FINISH
  } fst_t;
  logic [7:0]  r_sum, w_sum_n;
`else
  typedef enum logic [2:0] {
    WAIT_SYNC, GET_LEN, GET_DATA, FINISH
  } fst_t;
`endif

  ust_t        r_ust, w_ust_n;
  logic [1:0]  r_sync;
  logic        r_rx_q;
  logic        w_rx;
  logic [15:0] r_ucnt, w_ucnt_n;
  logic [2:0]  r_bit, w_bit_n;
  logic [7:0]  r_shift, w_shift_n;
  logic        w_byte_vld, w_frm_err;

  fst_t        r_fst, w_fst_n;
  logic [7:0]  r_len, w_len_n;
  logic [7:0]  r_idx, w_idx_n;
  logic [10:0] r_addr, w_addr_n;
  logic [7:0]  r_data, w_data_n;
  logic        r_we, w_we_n;
  logic        r_hold, w_hold_n;
  logic        r_err, w_err_n;

  assign w_rx = r_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= 2'b11;
      r_rx_q  <= 1'b1;
      r_ust   <= U_IDLE;
      r_ucnt  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_sync  <= {r_sync[0], rx};
      r_rx_q  <= w_rx;
      r_ust   <= w_ust_n;
      r_ucnt  <= w_ucnt_n;
      r_bit   <= w_bit_n;
      r_shift <= w_shift_n;
    end
  end

  always_comb begin
    w_ust_n    = r_ust;
    w_ucnt_n   = r_ucnt + 16'd1;
    w_bit_n    = r_bit;
    w_shift_n  = r_shift;
    w_byte_vld = 1'b0;
    w_frm_err  = 1'b0;
    unique case (r_ust)
      U_IDLE: begin
        w_ucnt_n = '0;
        if (r_rx_q && !w_rx) w_ust_n = U_START;
      end
      U_START: if (r_ucnt == HALF_END) begin
        w_ucnt_n = '0;
        w_bit_n  = '0;
        w_ust_n  = w_rx ? U_IDLE : U_DATA;
      end
      U_DATA: if (r_ucnt == BIT_END) begin
        w_ucnt_n  = '0;
        w_shift_n = {w_rx, r_shift[7:1]};
        w_bit_n   = r_bit + 3'd1;
        if (r_bit == 3'd7) w_ust_n = U_STOP;
      end
      U_STOP: if (r_ucnt == BIT_END) begin
        w_ucnt_n   = '0;
        w_ust_n    = U_IDLE;
        w_byte_vld = w_rx;
        w_frm_err  = !w_rx;
      end
      default: w_ust_n = U_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fst  <= WAIT_SYNC;
      r_len  <= '0;
      r_idx  <= '0;
      r_addr <= START_ADDR;
      r_data <= '0;
      r_we   <= 1'b0;
      r_hold <= 1'b0;
      r_err  <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      r_sum  <= '0;
`endif
    end else begin
      r_fst  <= w_fst_n;
      r_len  <= w_len_n;
      r_idx  <= w_idx_n;
      r_addr <= w_addr_n;
      r_data <= w_data_n;
      r_we   <= w_we_n;
      r_hold <= w_hold_n;
      r_err  <= w_err_n;
`ifdef PROG_LOADER_CHECKSUM_EN
      r_sum  <= w_sum_n;
`endif
    end
  end

  always_comb begin
    w_fst_n  = r_fst;
    w_len_n  = r_len;
    w_idx_n  = r_idx;
    w_addr_n = r_addr;
    w_data_n = r_data;
    w_we_n   = 1'b0;
    w_hold_n = r_hold;
    w_err_n  = r_err;
`ifdef PROG_LOADER_CHECKSUM_EN
    w_sum_n  = r_sum;
`endif
    if (w_frm_err) begin
      w_fst_n = WAIT_SYNC;
      w_err_n = 1'b1;
    end else begin
      unique case (r_fst)
        WAIT_SYNC: if (w_byte_vld && r_shift == SYNC) begin
          w_fst_n  = GET_LEN;
          w_err_n  = 1'b0;
          w_hold_n = 1'b1;
        end
        GET_LEN: if (w_byte_vld) begin
          // len 0 wraps to 255 as last index, giving 256 bytes
          w_len_n = r_shift;
          w_idx_n = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
          w_sum_n = '0;
`endif
          w_fst_n = GET_DATA;
        end
        GET_DATA: if (w_byte_vld) begin
          w_we_n   = 1'b1;
          w_addr_n = START_ADDR + {3'b000, r_idx};
          w_data_n = r_shift;
          w_idx_n  = r_idx + 8'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
          w_sum_n  = r_sum + r_shift;
          if (r_idx == r_len - 8'd1) w_fst_n = GET_SUM;
`else
          if (r_idx == r_len - 8'd1) begin
            w_fst_n  = FINISH;
            w_hold_n = 1'b0;
          end
`endif
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        GET_SUM: if (w_byte_vld) begin
          if (r_shift == r_sum) begin
            w_fst_n  = FINISH;
            w_hold_n = 1'b0;
          end else begin
            w_fst_n = WAIT_SYNC;
            w_err_n = 1'b1;
          end
        end
`endif
        FINISH:  w_fst_n = WAIT_SYNC;
        default: w_fst_n = WAIT_SYNC;
      endcase
    end
  end

  assign ram.ram_addr = r_addr;
  assign ram.ram_data = r_data;
  assign ram.ram_we   = r_we;
  assign cpu_hold     = r_hold;
  assign load_done    = (r_fst == FINISH);
  assign load_err     = r_err;
endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: directed UART frames, queued writes.
module tb_prog_loader;
  localparam int CPB = 4;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic cpu_hold, load_done, load_err;

  prog_loader_if ram_if ();

  prog_loader #(
    .CLKS_PER_BIT(CPB),
    .START_ADDR  (11'h000)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .ram      (ram_if),
    .cpu_hold (cpu_hold),
    .load_done(load_done),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        done;
    logic [10:0] addr;
    logic [7:0]  data;
  } ev_t;

  ev_t q[$];
  ev_t e_w, e_d;
  int  n_pass = 0;
  int  n_tot = 0;
  logic prev_we = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic exp_w(input logic [10:0] a, input logic [7:0] d);
    ev_t e;
    e.done = 1'b0;
    e.addr = a;
    e.data = d;
    q.push_back(e);
  endtask

  task automatic exp_d();
    ev_t e;
    e.done = 1'b1;
    e.addr = '0;
    e.data = '0;
    q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic settle(input string nm);
    repeat (4 * CPB) @(negedge clk);
    chk({nm, "_drained"}, q.size(), 0);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_we"}, ram_if.ram_we, 0);
    chk({nm, "_addr"}, ram_if.ram_addr, 0);
    chk({nm, "_data"}, ram_if.ram_data, 0);
    chk({nm, "_hold"}, cpu_hold, 0);
    chk({nm, "_done"}, load_done, 0);
    chk({nm, "_err"}, load_err, 0);
  endtask

  always @(negedge clk) begin
    if (ram_if.ram_we) begin
      chk("we_single", prev_we, 0);
      chk("write_pending", 32'(q.size() != 0), 1);
      if (q.size() != 0) begin
        e_w = q.pop_front();
        chk("write_kind", e_w.done, 0);
        chk("write_addr", ram_if.ram_addr, e_w.addr);
        chk("write_data", ram_if.ram_data, e_w.data);
      end
    end
    if (load_done) begin
      chk("done_pending", 32'(q.size() != 0), 1);
      if (q.size() != 0) begin
        e_d = q.pop_front();
        chk("done_kind", e_d.done, 1);
      end
    end
    prev_we = ram_if.ram_we;
  end

  initial begin
    repeat (3) @(negedge clk);
    #1 chk_reset("rst0");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // A5 03 42 05 12 59
    exp_w(11'd0, 8'h42);
    exp_w(11'd1, 8'h05);
    exp_w(11'd2, 8'h12);
    exp_d();
    send_byte(8'hA5);
    send_byte(8'h03);
    chk("f1_hold_mid", cpu_hold, 1);
    send_byte(8'h42);
    send_byte(8'h05);
    send_byte(8'h12);
    send_byte(8'h59);
    settle("f1");
    chk("f1_err", load_err, 0);
    chk("f1_hold", cpu_hold, 0);

    // A5 02 11 22 00: bad checksum
    exp_w(11'd0, 8'h11);
    exp_w(11'd1, 8'h22);
    if (!CK) exp_d();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h00);
    settle("f2");
    chk("f2_err", load_err, 32'(CK));
    chk("f2_hold", cpu_hold, 32'(CK));

    // 55 A5 01 A5 [A5]
    send_byte(8'h55);
    exp_w(11'd0, 8'hA5);
    exp_d();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'hA5);
    if (CK) send_byte(8'hA5);
    settle("f3");
    chk("f3_err", load_err, 0);
    chk("f3_hold", cpu_hold, 0);

    // A5 00, 256 x 01, 00
    for (int i = 0; i < 256; i++) exp_w(11'(i), 8'h01);
    exp_d();
    send_byte(8'hA5);
    send_byte(8'h00);
    for (int i = 0; i < 256; i++) send_byte(8'h01);
    send_byte(8'h00);
    settle("f4");
    chk("f4_err", load_err, 0);
    chk("f4_hold", cpu_hold, 0);

    // one-cycle glitch, then framing error
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (6 * CPB) @(negedge clk);
    chk("glitch_err", load_err, 0);
    send_byte(8'h3C, 1'b0);
    settle("f5");
    chk("f5_err", load_err, 1);
    chk("f5_hold", cpu_hold, 0);

    // reset after 2nd data byte of a 5-byte frame
    exp_w(11'd0, 8'h10);
    exp_w(11'd1, 8'h20);
    send_byte(8'hA5);
    send_byte(8'h05);
    send_byte(8'h10);
    send_byte(8'h20);
    chk("f6_hold_mid", cpu_hold, 1);
    chk("f6_err_mid", load_err, 0);
    chk("f6_data_mid", ram_if.ram_data, 8'h20);
    rst_n = 1'b0;
    #1 chk_reset("rst1");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    send_byte(8'h30);
    send_byte(8'h40);
    send_byte(8'h50);
    settle("f6");

    // recovery frame A5 02 AA BB [65]
    exp_w(11'd0, 8'hAA);
    exp_w(11'd1, 8'hBB);
    exp_d();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'hAA);
    send_byte(8'hBB);
    if (CK) send_byte(8'h65);
    settle("f7");
    chk("f7_err", load_err, 0);
    chk("f7_hold", cpu_hold, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clk cycles per UART bit (minimum 4).
REQ-002 SHALL have parameter START_ADDR, default 11'h000, RAM address of the first loaded byte.
REQ-003 SHALL have port clk  in  1  single clock for all logic, rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port rx  in  1  UART serial input, 8N1, LSB first, idle high.
REQ-006 SHALL have port ram_addr  out  11  program-RAM write address (port B).
REQ-007 SHALL have port ram_data  out  8  program-RAM write data.
REQ-008 SHALL have port ram_we  out  1  one-cycle write strobe.
REQ-009 SHALL have port cpu_hold  out  1  high = CPU must not fetch or execute.
REQ-010 SHALL have port load_done  out  1  one-cycle pulse on successful frame.
REQ-011 SHALL have port load_err  out  1  sticky error flag.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer; all sampling uses the synchronized value.
REQ-013 UART RX SHALL detect start on a 1->0 transition, recheck low at CLKS_PER_BIT/2, and return to idle if high (false start, no error).
REQ-014 SHALL sample the 8 data bits and the stop bit each CLKS_PER_BIT cycles after the start-bit midpoint.
REQ-015 A low stop bit SHALL be a framing error: discard byte, set load_err, frame FSM to WAIT_SYNC.
REQ-016 Frame FSM states: WAIT_SYNC, GET_LEN, GET_DATA, GET_SUM, FINISH.
REQ-017 WAIT_SYNC: byte 0xA5 -> GET_LEN, clear load_err, set cpu_hold; any other byte ignored.
REQ-018 GET_LEN: byte L gives count N = L, with L = 0 meaning N = 256; -> GET_DATA; clear index and checksum.
REQ-019 GET_DATA: each byte SHALL produce ram_we = 1 for exactly one cycle, the cycle after stop-bit sample, with ram_addr = (START_ADDR + index) mod 2048 and ram_data = byte.
REQ-020 GET_DATA SHALL accumulate checksum = 8-bit modulo sum of data bytes; after the Nth byte -> GET_SUM.
REQ-021 GET_SUM: received byte == checksum -> FINISH; else set load_err, keep cpu_hold = 1, -> WAIT_SYNC.
REQ-022 FINISH (one cycle): load_done = 1, cpu_hold = 0, -> WAIT_SYNC.
REQ-023 cpu_hold SHALL remain 1 after any error until a later frame completes successfully.
REQ-024 0xA5 inside GET_LEN, GET_DATA or GET_SUM SHALL be treated as payload, not sync.
REQ-025 ram_addr and ram_data SHALL hold the last written values between strobes; ram_we is never high for two consecutive cycles.
REQ-026 Bytes already written before an error SHALL stay in RAM; no rollback.

Reset
REQ-027 rst_n low SHALL immediately force: UART idle, FSM WAIT_SYNC, ram_we = 0, ram_addr = START_ADDR, ram_data = 0, cpu_hold = 0, load_done = 0, load_err = 0.
REQ-028 Reset mid-frame SHALL abort the frame with no further writes; the next byte after release is treated as a WAIT_SYNC candidate.

Configuration
REQ-029 Macro PROG_LOADER_CHECKSUM_EN defined: GET_SUM is present as in REQ-021.
REQ-030 Macro PROG_LOADER_CHECKSUM_EN undefined: GET_SUM and the checksum logic are removed; after the Nth data byte the FSM SHALL go directly to FINISH, and load_err is set only by framing errors.

Verification (bench CLKS_PER_BIT = 4, START_ADDR = 0)
REQ-031 Send A5 03 42 05 12 59 -> writes 0x42@0, 0x05@1, 0x12@2; load_done pulses once; cpu_hold 1 to 0; load_err = 0.
REQ-032 Send A5 02 11 22 00 -> two writes, load_err = 1, cpu_hold stays 1, no load_done; with checksum disabled, load_done pulses after 0x22.
REQ-033 Send 55 A5 01 A5 A5 -> 0x55 ignored; 0xA5 written @0; frame succeeds.
REQ-034 Send A5 00, 256 bytes of 0x01, then 00 -> 256 writes at addr 0..255; checksum 0x00 passes.
REQ-035 1-cycle rx glitch low, then byte with stop bit forced low -> glitch ignored; framing error sets load_err, no ram_we.
REQ-036 Assert rst_n low after the 2nd data byte of a 5-byte frame -> outputs at reset values immediately; no further ram_we; a following good frame loads correctly.
